prior_wrr_scheduler: RTL and testbench

//  Per-egress-port packet scheduler for hydra. Picks which of the 8 priority queues of one

---
 rtl/prior_wrr_scheduler.sv | 125 ++++++++++++
 tb/tb_prior_wrr_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prior_wrr_scheduler.sv
// Per-port packet scheduler: picks one of NUM_PRI priority queues by strict priority or
// weighted round robin, issues a single read request, then waits for the packet to finish.
module prior_wrr_scheduler #(
    parameter int unsigned NUM_PRI = 8,
    parameter int unsigned CRED_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wrr_en,
    input  logic                       ready,
    input  logic [NUM_PRI-1:0]         queue_nonempty,
    input  logic                       pkt_done,
    output logic                       rd_req,
    output logic [$clog2(NUM_PRI)-1:0] rd_pri,
    output logic                       busy
);

    localparam int unsigned PRI_W = $clog2(NUM_PRI);

    typedef enum logic [1:0] {StIdle, StSel, StIssue, StWait} state_e;

    state_e                  state_q, state_d;
    logic                    ready_pend_q, ready_pend_d;
    logic                    rd_req_q, rd_req_d;
    logic [PRI_W-1:0]        rd_pri_q, rd_pri_d;
    logic                    busy_q, busy_d;
    logic [CRED_W-1:0]       credit_q [NUM_PRI];
    logic [CRED_W-1:0]       credit_d [NUM_PRI];

    logic                    strict_hit, wrr_hit;
    logic [PRI_W-1:0]        strict_idx, wrr_idx;

    // Scan from the bottom so the lowest eligible index wins.
    always_comb begin
        strict_hit = 1'b0;
        strict_idx = '0;
        wrr_hit    = 1'b0;
        wrr_idx    = '0;
        for (int p = int'(NUM_PRI) - 1; p >= 0; p--) begin
            if (queue_nonempty[p]) begin
                strict_hit = 1'b1;
                strict_idx = PRI_W'(p);
                if (credit_q[p] != '0) begin
                    wrr_hit = 1'b1;
                    wrr_idx = PRI_W'(p);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ready_pend_d = ready_pend_q | ready;
        rd_req_d     = 1'b0;
        rd_pri_d     = rd_pri_q;
        credit_d     = credit_q;

        unique case (state_q)
            StIdle: begin
                if ((ready || ready_pend_q) && strict_hit) begin
                    state_d = StSel;
                end
            end
            StSel: begin
                if (!strict_hit) begin
                    state_d = StIdle;
                end else if (!wrr_en) begin
                    state_d      = StIssue;
                    rd_req_d     = 1'b1;
                    rd_pri_d     = strict_idx;
                    ready_pend_d = ready;
                end else if (wrr_hit) begin
                    state_d           = StIssue;
                    rd_req_d          = 1'b1;
                    rd_pri_d          = wrr_idx;
                    ready_pend_d      = ready;
                    credit_d[wrr_idx] = credit_q[wrr_idx] - 1'b1;
                end else begin
                    // Round boundary: every nonempty queue is out of credit.
                    for (int p = 0; p < int'(NUM_PRI); p++) begin
                        credit_d[p] = CRED_W'(int'(NUM_PRI) - p);
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (pkt_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ready_pend_q <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_pri_q     <= '0;
            busy_q       <= 1'b0;
            for (int p = 0; p < int'(NUM_PRI); p++) begin
                credit_q[p] <= CRED_W'(int'(NUM_PRI) - p);
            end
        end else begin
            state_q      <= state_d;
            ready_pend_q <= ready_pend_d;
            rd_req_q     <= rd_req_d;
            rd_pri_q     <= rd_pri_d;
            busy_q       <= busy_d;
            credit_q     <= credit_d;
        end
    end

    assign rd_req = rd_req_q;
    assign rd_pri = rd_pri_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_prior_wrr_scheduler.sv
// Bench for prior_wrr_scheduler: table of single-grant vectors plus hand sequences for
// WRR rounds, late nonempty, reset in WAIT, stray pkt_done and ready held while busy.
module tb_prior_wrr_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wrr_en = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] queue_nonempty = '0;
    logic       pkt_done = 1'b0;
    logic       rd_req;
    logic [2:0] rd_pri;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;
    logic [2:0] exp_q [$];

    typedef struct {
        logic       wrr;
        logic [7:0] ne;
        logic [2:0] pri;
        int         lat;
    } vec_t;

    vec_t vecs [11];

    prior_wrr_scheduler #(.NUM_PRI(8), .CRED_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .wrr_en         (wrr_en),
        .ready          (ready),
        .queue_nonempty (queue_nonempty),
        .pkt_done       (pkt_done),
        .rd_req         (rd_req),
        .rd_pri         (rd_pri),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ready = 1'b0;
        pkt_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Waits for rd_req; n0 = negedges already elapsed since the triggering stimulus.
    task automatic wait_req(input logic [2:0] exp_pri, input int exp_lat, input int n0,
                            input string name);
        int n;
        logic [2:0] e;
        n = n0;
        exp_q.push_back(exp_pri);
        while (!rd_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        if (!rd_req) begin
            check({name, " rd_req timeout"}, 0, 1);
        end else begin
            check({name, " rd_pri"}, int'(rd_pri), int'(e));
            if (exp_lat > 0) check({name, " latency"}, n, exp_lat);
            @(negedge clk);
            check({name, " rd_req one cycle"}, int'(rd_req), 0);
        end
    endtask

    task automatic finish_pkt(input int delay, input string name);
        repeat (delay - 2) @(negedge clk);
        check({name, " busy in wait"}, int'(busy), 1);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        check({name, " busy after done"}, int'(busy), 0);
    endtask

    task automatic run_pkt(input logic [2:0] exp_pri, input int exp_lat, input string name);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check({name, " busy at T+1"}, int'(busy), 1);
        wait_req(exp_pri, exp_lat, 1, name);
        finish_pkt(5, name);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h81, 3'd0, 2};
        vecs[1]  = '{1'b0, 8'h81, 3'd0, 2};
        vecs[2]  = '{1'b0, 8'h81, 3'd0, 2};
        vecs[3]  = '{1'b0, 8'h04, 3'd2, 2};
        vecs[4]  = '{1'b0, 8'hF0, 3'd4, 2};
        vecs[5]  = '{1'b0, 8'h80, 3'd7, 2};
        vecs[6]  = '{1'b0, 8'h06, 3'd1, 2};
        vecs[7]  = '{1'b0, 8'h60, 3'd5, 2};
        vecs[8]  = '{1'b1, 8'h80, 3'd7, 2};  // pri 7 uses its single credit
        vecs[9]  = '{1'b1, 8'h80, 3'd7, 3};  // no credit left: reload costs a cycle
        vecs[10] = '{1'b1, 8'h82, 3'd1, 2};

        #1 rst = 1'b1;
        #1;
        check("reset rd_req", int'(rd_req), 0);
        check("reset rd_pri", int'(rd_pri), 0);
        check("reset busy", int'(busy), 0);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            wrr_en = vecs[i].wrr;
            queue_nonempty = vecs[i].ne;
            run_pkt(vecs[i].pri, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Full WRR round from fresh credits: 8,7,..,1 grants, then a reload.
        do_reset();
        wrr_en = 1'b1;
        queue_nonempty = 8'hFF;
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < 8 - p; k++) begin
                run_pkt(3'(p), 2, $sformatf("wrr p%0d k%0d", p, k));
            end
        end
        run_pkt(3'd0, 3, "wrr grant37");

        // Ready arrives before any queue is nonempty; it must be remembered.
        wrr_en = 1'b0;
        queue_nonempty = 8'h00;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (4) @(negedge clk);
        check("late ne busy idle", int'(busy), 0);
        queue_nonempty = 8'h10;
        wait_req(3'd4, 2, 0, "late ne");
        finish_pkt(5, "late ne");

        // Reset during WAIT after partially draining pri 0 credit.
        do_reset();
        wrr_en = 1'b1;
        queue_nonempty = 8'hFF;
        for (int k = 0; k < 3; k++) run_pkt(3'd0, 2, "pre-rst");
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        wait_req(3'd0, 2, 1, "rst pkt");
        rst = 1'b1;
        #1;
        check("rst in wait busy", int'(busy), 0);
        check("rst in wait rd_req", int'(rd_req), 0);
        check("rst in wait rd_pri", int'(rd_pri), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) run_pkt(3'd0, 2, $sformatf("post-rst %0d", k));
        run_pkt(3'd1, 2, "post-rst p1");

        // Stray pkt_done in IDLE and in ISSUE.
        wrr_en = 1'b0;
        queue_nonempty = 8'h04;
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        @(negedge clk);
        check("done in idle busy", int'(busy), 0);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        check("issue rd_req", int'(rd_req), 1);
        check("issue rd_pri", int'(rd_pri), 2);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        check("done in issue busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        check("wait holds busy", int'(busy), 1);
        check("wait holds rd_pri", int'(rd_pri), 2);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        check("done in wait busy", int'(busy), 0);

        // Ready seen while busy triggers the next grant on its own.
        queue_nonempty = 8'h20;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        wait_req(3'd5, 2, 1, "pend first");
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        finish_pkt(5, "pend first");
        wait_req(3'd5, 2, 0, "pend second");
        finish_pkt(5, "pend second");
        repeat (4) @(negedge clk);
        check("pend consumed", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
